// File: rtl/pgm_out_buf_pkg.sv
// Shared definitions for the PGM output buffer: word layout, position codes,
// FIFO geometry and the output FSM state encoding.
package pgm_out_buf_pkg;

  localparam int WORD_W  = 134;
  localparam int DATA_AW = 8;   // 256-word data FIFO
  localparam int FLAG_AW = 5;   // 32-entry flag FIFO

  localparam logic [1:0] POS_HEAD = 2'b01;
  localparam logic [1:0] POS_MID  = 2'b11;
  localparam logic [1:0] POS_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_DISCARD = 2'd2
  } obuf_state_t;

  // Position code carried in the top two bits of every packet word.
  function automatic logic [1:0] word_pos(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pgm_out_buf_if.sv
// Data-plane bundle between PGM, the output buffer and UDO.
// slave = buffer side, master = PGM/UDO side.
interface pgm_out_buf_if;

  logic [pgm_out_buf_pkg::WORD_W-1:0] in_data;
  logic                               in_data_wr;
  logic                               in_data_valid;
  logic                               in_data_valid_wr;
  logic                               in_out_alf;
  logic [7:0]                         out_pgm_fifo_usedw;
  logic [pgm_out_buf_pkg::WORD_W-1:0] out_data;
  logic                               out_data_wr;
  logic                               out_data_valid;
  logic                               out_data_valid_wr;
  logic [31:0]                        out_drop_cnt;

  modport slave (
    input  in_data, in_data_wr, in_data_valid, in_data_valid_wr, in_out_alf,
    output out_pgm_fifo_usedw, out_data, out_data_wr, out_data_valid,
           out_data_valid_wr, out_drop_cnt
  );

  modport master (
    output in_data, in_data_wr, in_data_valid, in_data_valid_wr, in_out_alf,
    input  out_pgm_fifo_usedw, out_data, out_data_wr, out_data_valid,
           out_data_valid_wr, out_drop_cnt
  );

endinterface

// File: rtl/pgm_obuf_fifo.sv
// Show-ahead synchronous FIFO; PLATFORM picks the vendor RAM mapping.
// rd_data always holds the oldest entry while empty = 0.
module pgm_obuf_fifo #(
  parameter     PLATFORM = "xilinx",
  parameter int WIDTH    = 134,
  parameter int AW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      usedw,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  rd_ptr_next;
  logic [AW:0]    cnt_reg;
  logic           full;
  logic           wr_ok;
  logic           rd_ok;
  logic [WIDTH-1:0] ram_q;
  logic             byp_reg;
  logic [WIDTH-1:0] byp_data_reg;

  assign empty       = (cnt_reg == '0);
  assign full        = cnt_reg[AW];
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign rd_ptr_next = rd_ptr_reg + AW'(rd_ok);
  assign usedw       = cnt_reg;

  // The RAM is read at the address that will be the head after this cycle,
  // so its registered output is already the next show-ahead word.
  generate
    if (PLATFORM == "altera") begin : g_altera
      (* ramstyle = "no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= wr_data;
        ram_q <= mem[rd_ptr_next];
      end
    end else begin : g_xilinx
      (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= wr_data;
        ram_q <= mem[rd_ptr_next];
      end
    end
  endgenerate

  // Writing the slot that becomes the head this cycle: RAM would return
  // stale data, so forward the write word instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_reg      <= wr_ok && (wr_ptr_reg == rd_ptr_next);
      byp_data_reg <= wr_data;
    end
  end

  assign rd_data = byp_reg ? byp_data_reg : ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
        2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/pgm_out_buf.sv
// PGM output buffer: admits or drops packets at the head word, then forwards
// kept packets to UDO under downstream almost-full. Optional counters: PGM_OBUF_STATS_EN.
module pgm_out_buf
  import pgm_out_buf_pkg::*;
#(
  parameter             PLATFORM = "xilinx",
  parameter logic [7:0] DROP_TH  = 8'd160
) (
  input  logic               clk,
  input  logic               rst,
  pgm_out_buf_if.slave       bus
`ifdef PGM_OBUF_STATS_EN
  ,
  output logic [31:0]        out_tx_pkt_cnt,
  output logic [31:0]        out_inv_pkt_cnt
`endif
);

  logic [WORD_W-1:0]  data_q;
  logic [DATA_AW:0]   data_cnt;
  logic               data_empty;
  logic               data_wr;
  logic               data_rd;
  logic [0:0]         flag_q;
  logic [FLAG_AW:0]   flag_cnt;
  logic               flag_empty;
  logic               flag_wr;
  logic               flag_rd;

  logic [1:0]         in_pos;
  logic               in_head;
  logic               in_body;
  logic               in_tail;
  logic [FLAG_AW:0]   flag_pend;
  logic               admit;

  logic               in_pkt_reg;
  logic               drop_reg;
  logic               owed_reg;
  logic [31:0]        drop_cnt_reg;

  obuf_state_t        state_reg;
  obuf_state_t        state_next;
  logic               send_word;
  logic               send_tail;
  logic               data_tail;
  logic [WORD_W-1:0]  out_data_reg;
  logic               out_wr_reg;
  logic               out_vwr_reg;
  logic               out_valid_reg;

  // ---------------- admission ----------------
  assign in_pos  = word_pos(bus.in_data);
  assign in_head = bus.in_data_wr && (in_pos == POS_HEAD);
  assign in_body = bus.in_data_wr && ((in_pos == POS_MID) || (in_pos == POS_TAIL));
  assign in_tail = bus.in_data_wr && (in_pos == POS_TAIL);

  // An admitted packet whose flag has not arrived yet already owns a flag slot.
  assign flag_pend = flag_cnt + (FLAG_AW+1)'(owed_reg);
  assign admit     = (data_cnt < {1'b0, DROP_TH}) && !flag_pend[FLAG_AW];

  assign data_wr = (in_head && admit) || (in_body && in_pkt_reg && !drop_reg);
  // The flag of a packet is expected before the next packet's head.
  assign flag_wr = bus.in_data_valid_wr && owed_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_reg   <= 1'b0;
      drop_reg     <= 1'b0;
      owed_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (in_head) begin
        in_pkt_reg <= 1'b1;
        drop_reg   <= !admit;
      end else if (in_tail) begin
        in_pkt_reg <= 1'b0;
      end
      if (in_head && admit) owed_reg <= 1'b1;
      else if (flag_wr)     owed_reg <= 1'b0;
      if (in_tail && in_pkt_reg && drop_reg) drop_cnt_reg <= drop_cnt_reg + 32'd1;
    end
  end

  pgm_obuf_fifo #(
    .PLATFORM (PLATFORM),
    .WIDTH    (WORD_W),
    .AW       (DATA_AW)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (data_wr),
    .wr_data (bus.in_data),
    .rd_en   (data_rd),
    .rd_data (data_q),
    .usedw   (data_cnt),
    .empty   (data_empty)
  );

  pgm_obuf_fifo #(
    .PLATFORM (PLATFORM),
    .WIDTH    (1),
    .AW       (FLAG_AW)
  ) u_flag_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (flag_wr),
    .wr_data (bus.in_data_valid),
    .rd_en   (flag_rd),
    .rd_data (flag_q),
    .usedw   (flag_cnt),
    .empty   (flag_empty)
  );

  // ---------------- output FSM ----------------
  assign data_tail = (word_pos(data_q) == POS_TAIL);

  always_comb begin
    state_next = state_reg;
    flag_rd    = 1'b0;
    data_rd    = 1'b0;
    send_word  = 1'b0;
    send_tail  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (!flag_empty) begin
          if (!flag_q[0]) begin
            flag_rd    = 1'b1;
            state_next = ST_DISCARD;
          end else if (!bus.in_out_alf) begin
            flag_rd    = 1'b1;
            state_next = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (!bus.in_out_alf && !data_empty) begin
          data_rd   = 1'b1;
          send_word = 1'b1;
          if (data_tail) begin
            send_tail  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (!data_empty) begin
          data_rd = 1'b1;
          if (data_tail) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_data_reg  <= '0;
      out_wr_reg    <= 1'b0;
      out_vwr_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      out_wr_reg  <= send_word;
      out_vwr_reg <= send_tail;
      if (send_word) out_data_reg  <= data_q;
      if (send_tail) out_valid_reg <= 1'b1;
    end
  end

  assign bus.out_data           = out_data_reg;
  assign bus.out_data_wr        = out_wr_reg;
  assign bus.out_data_valid     = out_valid_reg;
  assign bus.out_data_valid_wr  = out_vwr_reg;
  assign bus.out_pgm_fifo_usedw = data_cnt[DATA_AW-1:0];
  assign bus.out_drop_cnt       = drop_cnt_reg;

`ifdef PGM_OBUF_STATS_EN
  logic [31:0] tx_pkt_cnt_reg;
  logic [31:0] inv_pkt_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pkt_cnt_reg  <= '0;
      inv_pkt_cnt_reg <= '0;
    end else begin
      if (send_tail)              tx_pkt_cnt_reg  <= tx_pkt_cnt_reg + 32'd1;
      if (flag_rd && !flag_q[0])  inv_pkt_cnt_reg <= inv_pkt_cnt_reg + 32'd1;
    end
  end

  assign out_tx_pkt_cnt  = tx_pkt_cnt_reg;
  assign out_inv_pkt_cnt = inv_pkt_cnt_reg;
`endif

endmodule

// File: tb/tb_pgm_out_buf.sv
// Self-checking bench for pgm_out_buf: expected output words are queued when
// packets are driven and compared as the DUT emits them.
module tb_pgm_out_buf;
  import pgm_out_buf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pgm_out_buf_if bus();

`ifdef PGM_OBUF_STATS_EN
  logic [31:0] tx_cnt;
  logic [31:0] inv_cnt;
`endif

  pgm_out_buf #(
    .PLATFORM ("xilinx"),
    .DROP_TH  (8'd160)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PGM_OBUF_STATS_EN
    ,
    .out_tx_pkt_cnt  (tx_cnt),
    .out_inv_pkt_cnt (inv_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int word_no = 0;
  logic [WORD_W-1:0] exp_q[$];

  // Output monitor / scoreboard
  always @(posedge clk) begin : mon
    logic [WORD_W-1:0] exp_w;
    #1;
    if (bus.out_data_wr === 1'b1) begin
      word_no++;
      $display("out word %0d data=%h valid_wr=%b", word_no, bus.out_data, bus.out_data_valid_wr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word_unexpected got=%h expected=none", bus.out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.out_data !== exp_w) begin
          errors++;
          $display("FAIL out_word_data got=%h expected=%h", bus.out_data, exp_w);
        end
        checks++;
        if (bus.out_data_valid_wr !== (exp_w[WORD_W-1 -: 2] == POS_TAIL)) begin
          errors++;
          $display("FAIL out_valid_wr_align got=%b expected=%b", bus.out_data_valid_wr,
                   (exp_w[WORD_W-1 -: 2] == POS_TAIL));
        end
        if (exp_w[WORD_W-1 -: 2] == POS_TAIL) begin
          checks++;
          if (bus.out_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_data_valid got=%b expected=1", bus.out_data_valid);
          end
        end
      end
    end else if (bus.out_data_valid_wr === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_wr_without_word got=1 expected=0");
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one packet, flag strobed with the tail; returns 1ns after the
  // edge that sampled the tail.
  task automatic drive_pkt(input int nw, input logic flag, input logic expect_out);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < nw; i++) begin
      w[WORD_W-1 -: 2] = (i == 0) ? POS_HEAD : ((i == nw - 1) ? POS_TAIL : POS_MID);
      w[131:128] = 4'(i % 16);
      w[127:0] = {$urandom, $urandom, $urandom, $urandom};
      bus.in_data          = w;
      bus.in_data_wr       = 1'b1;
      bus.in_data_valid_wr = (i == nw - 1);
      bus.in_data_valid    = flag;
      if (expect_out) exp_q.push_back(w);
      cyc(1);
    end
    bus.in_data_wr       = 1'b0;
    bus.in_data_valid_wr = 1'b0;
    bus.in_data_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++; if (bus.out_data_wr !== 1'b0) begin errors++; $display("FAIL reset_data_wr got=%b expected=0", bus.out_data_wr); end
    checks++; if (bus.out_data_valid_wr !== 1'b0) begin errors++; $display("FAIL reset_valid_wr got=%b expected=0", bus.out_data_valid_wr); end
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd0) begin errors++; $display("FAIL reset_usedw got=%0d expected=0", bus.out_pgm_fifo_usedw); end
    checks++; if (bus.out_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d expected=0", bus.out_drop_cnt); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h expected=0", bus.out_data); end
    checks++; if (bus.out_data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b expected=0", bus.out_data_valid); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_send();
    int lat, last, seen, vwr_pos;
    lat = 0; last = 0; seen = 0; vwr_pos = 0;
    drive_pkt(4, 1'b1, 1'b1);
    for (int c = 1; c <= 40 && seen < 4; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) begin
        seen++;
        if (seen == 1) lat = c;
        last = c;
        if (bus.out_data_valid_wr === 1'b1) vwr_pos = seen;
      end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL send_first_latency got=%0d expected=2", lat); end
    checks++; if (seen != 4) begin errors++; $display("FAIL send_word_count got=%0d expected=4", seen); end
    checks++; if (last - lat != 3) begin errors++; $display("FAIL send_back_to_back span got=%0d expected=3", last - lat); end
    checks++; if (vwr_pos != 4) begin errors++; $display("FAIL send_valid_wr_pos got=%0d expected=4", vwr_pos); end
    cyc(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL send_scoreboard_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_discard();
    int seen;
    seen = 0;
    drive_pkt(4, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL discard_words_out got=%0d expected=0", seen); end
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd0) begin errors++; $display("FAIL discard_usedw got=%0d expected=0", bus.out_pgm_fifo_usedw); end
    checks++; if (bus.out_drop_cnt !== 32'd0) begin errors++; $display("FAIL discard_drop_cnt got=%0d expected=0", bus.out_drop_cnt); end
  endtask

  task automatic test_drop();
    bus.in_out_alf = 1'b1;
    for (int p = 0; p < 16; p++) drive_pkt(10, 1'b1, 1'b1);
    cyc(2);
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd160) begin errors++; $display("FAIL drop_fill_usedw got=%0d expected=160", bus.out_pgm_fifo_usedw); end
    drive_pkt(3, 1'b1, 1'b0);
    cyc(2);
    checks++; if (bus.out_drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt got=%0d expected=1", bus.out_drop_cnt); end
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd160) begin errors++; $display("FAIL drop_usedw_hold got=%0d expected=160", bus.out_pgm_fifo_usedw); end
    bus.in_out_alf = 1'b0;
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) cyc(1);
    cyc(3);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drop_drain_timeout left=%0d expected=0", exp_q.size()); end
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd0) begin errors++; $display("FAIL drop_drain_usedw got=%0d expected=0", bus.out_pgm_fifo_usedw); end
  endtask

  task automatic test_alf();
    int seen, held, extra;
    seen = 0; held = 0; extra = 0;
    drive_pkt(8, 1'b1, 1'b1);
    for (int c = 0; c < 40 && seen < 3; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) seen++;
    end
    bus.in_out_alf = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) held++;
    end
    bus.in_out_alf = 1'b0;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) seen++;
    end
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) extra++;
    end
    checks++; if (held != 0) begin errors++; $display("FAIL alf_hold words=%0d expected=0", held); end
    checks++; if (seen + held != 8) begin errors++; $display("FAIL alf_word_count got=%0d expected=8", seen + held); end
    checks++; if (extra != 0) begin errors++; $display("FAIL alf_duplicate got=%0d expected=0", extra); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alf_scoreboard_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_stray();
    logic [WORD_W-1:0] w;
    logic [31:0] drops_before;
    drops_before = bus.out_drop_cnt;
    w = '0;
    w[WORD_W-1 -: 2] = POS_TAIL;
    w[31:0] = 32'hDEAD_0001;
    bus.in_data = w; bus.in_data_wr = 1'b1;
    cyc(1);
    w[WORD_W-1 -: 2] = POS_MID;
    bus.in_data = w;
    cyc(1);
    bus.in_data_wr = 1'b0;
    cyc(2);
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd0) begin errors++; $display("FAIL stray_usedw got=%0d expected=0", bus.out_pgm_fifo_usedw); end
    checks++; if (bus.out_drop_cnt !== drops_before) begin errors++; $display("FAIL stray_drop_cnt got=%0d expected=%0d", bus.out_drop_cnt, drops_before); end
  endtask

  task automatic test_rst_mid();
    int seen, lost;
    seen = 0; lost = 0;
    drive_pkt(6, 1'b1, 1'b1);
    for (int c = 0; c < 40 && seen < 2; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) seen++;
    end
    #1;
    exp_q.delete();
    rst = 1'b1;
    cyc(1);
    checks++; if (bus.out_data_wr !== 1'b0) begin errors++; $display("FAIL rstmid_data_wr got=%b expected=0", bus.out_data_wr); end
    checks++; if (bus.out_data_valid_wr !== 1'b0) begin errors++; $display("FAIL rstmid_valid_wr got=%b expected=0", bus.out_data_valid_wr); end
    checks++; if (bus.out_pgm_fifo_usedw !== 8'd0) begin errors++; $display("FAIL rstmid_usedw got=%0d expected=0", bus.out_pgm_fifo_usedw); end
    checks++; if (bus.out_drop_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_drop_cnt got=%0d expected=0", bus.out_drop_cnt); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rstmid_out_data got=%h expected=0", bus.out_data); end
    checks++; if (bus.out_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_data_valid got=%b expected=0", bus.out_data_valid); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) lost++;
    end
    checks++; if (lost != 0) begin errors++; $display("FAIL rstmid_truncated_out got=%0d expected=0", lost); end
    seen = 0;
    drive_pkt(4, 1'b1, 1'b1);
    for (int c = 0; c < 40 && seen < 4; c++) begin
      cyc(1);
      if (bus.out_data_wr === 1'b1) seen++;
    end
    cyc(2);
    checks++; if (seen != 4) begin errors++; $display("FAIL rstmid_next_pkt_words got=%0d expected=4", seen); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_scoreboard_left got=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data          = '0;
    bus.in_data_wr       = 1'b0;
    bus.in_data_valid    = 1'b0;
    bus.in_data_valid_wr = 1'b0;
    bus.in_out_alf       = 1'b0;
    cyc(1);
    test_reset();
    test_send();
    test_discard();
    test_drop();
    test_alf();
    test_stray();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pgm_out_buf.md
PGM_OUT_BUF -- requirements
Module: pgm_out_buf

Interface
REQ-001 Parameter PLATFORM, default "xilinx", SHALL select the vendor FIFO primitive wrapper.
REQ-002 Parameter DROP_TH, default 8'd160, SHALL be the data-FIFO usedw at or above which a new packet is dropped at its head.
REQ-003 Port list SHALL be:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_data  in  134  PGM packet word; [133:132] 01 head, 11 middle, 10 tail; [131:128] invalid bytes in word
- in_data_wr  in  1  in_data strobe
- in_data_valid  in  1  packet keep(1)/discard(0) flag
- in_data_valid_wr  in  1  flag strobe, once per packet, on or after the tail
- in_out_alf  in  1  downstream almost-full, stalls output
- out_pgm_fifo_usedw  out  8  data-FIFO occupancy, fed back to PGM
- out_data  out  134  packet word to UDO
- out_data_wr  out  1  out_data strobe
- out_data_valid  out  1  packet flag to UDO, always 1
- out_data_valid_wr  out  1  flag strobe, same cycle as the tail word
- out_drop_cnt  out  32  packets dropped on admission

Function
REQ-004 Data FIFO SHALL be 256 x 134, show-ahead; flag FIFO SHALL be 32 x 1.
REQ-005 Admission: at a head word with usedw >= DROP_TH, or flag FIFO full, all words of that packet and its flag SHALL be discarded and out_drop_cnt incremented by 1 at the tail.
REQ-006 An admitted packet SHALL be written in full; admission is decided only at the head word.
REQ-007 A middle/tail word arriving with no head in progress SHALL be discarded without counting.
REQ-008 Output FSM SHALL have states IDLE, SEND, DISCARD.
REQ-009 IDLE -> SEND when flag FIFO is non-empty, its head flag = 1 and in_out_alf = 0; IDLE -> DISCARD when its head flag = 0; the flag SHALL be popped on the transition.
REQ-010 SEND SHALL emit one word per cycle while in_out_alf = 0, hold while in_out_alf = 1, and return to IDLE after the tail word.
REQ-011 DISCARD SHALL pop one word per cycle, ignoring in_out_alf, and return to IDLE after the tail word; out_data_wr SHALL stay 0.
REQ-012 Output latency SHALL be 1 cycle from FIFO read to out_data_wr (registered outputs).
REQ-013 out_data_valid_wr SHALL pulse with the tail word of every sent packet, with out_data_valid = 1.
REQ-014 Simultaneous write and read SHALL leave usedw unchanged; a flag FIFO holding zero entries SHALL never be popped.
REQ-015 out_drop_cnt SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-016 On rst = 1 at a clk edge, both FIFOs SHALL flush, the FSM SHALL go to IDLE, and out_data_wr, out_data_valid_wr, out_pgm_fifo_usedw and out_drop_cnt SHALL be 0.
REQ-017 out_data and out_data_valid SHALL reset to 0; a packet in flight at reset SHALL be lost, never truncated on the output after reset.

Configuration
REQ-018 With PGM_OBUF_STATS_EN defined, outputs out_tx_pkt_cnt[31:0] (sent packets) and out_inv_pkt_cnt[31:0] (flag = 0 packets) SHALL exist, reset to 0 and wrap.
REQ-019 Without PGM_OBUF_STATS_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-020 A shared package SHALL hold the head/middle/tail codes (2'b01/2'b11/2'b10), the 134-bit word width, and the FSM state encoding.
REQ-021 One sub-module, pgm_obuf_fifo (sync FIFO wrapper selected by PLATFORM), SHALL be instantiated twice, for the data FIFO and the flag FIFO.

Verification
REQ-022 The bench SHALL cover these scenarios:
- 4-word packet, flag = 1, alf = 0 -> 4 words out, tail + valid_wr on the same cycle, first word 2 cycles after the flag write.
- 4-word packet, flag = 0 -> nothing out, usedw returns to 0, out_drop_cnt = 0.
- Fill to usedw = 160, then send a 3-word packet -> dropped, out_drop_cnt = 1, usedw stays 160.
- alf asserted mid-packet for 5 cycles -> output holds, resumes, no words lost or duplicated.
- Stray tail word with no head -> ignored, usedw unchanged.
- rst pulse during SEND -> all outputs 0 next cycle, a following packet is output intact.
